// File: rtl/cabac_pkg.sv
// Shared widths, reset constants and arithmetic helpers for the CABAC decoding core.
package cabac_pkg;

  localparam int unsigned RANGE_W = 9;
  localparam int unsigned VALUE_W = 16;
  localparam int unsigned EP_W    = 17;

  localparam logic [RANGE_W-1:0] RANGE_RESET = 9'd510;

  // LPS sub-range from the top range bits and the top probability bits.
  function automatic logic [RANGE_W-1:0] lps_range(logic [3:0] range_hi, logic [4:0] q_hi);
    logic [RANGE_W-1:0] prod;
    prod = {5'd0, range_hi} * {4'd0, q_hi};
    return (prod >> 1) + 9'd4;
  endfunction

  // Smallest shift bringing the LPS range back to at least 256; lps is always >= 4.
  function automatic logic [2:0] renorm_bits(logic [RANGE_W-1:0] lps);
    if (lps >= 9'd128)     return 3'd1;
    else if (lps >= 9'd64) return 3'd2;
    else if (lps >= 9'd32) return 3'd3;
    else if (lps >= 9'd16) return 3'd4;
    else if (lps >= 9'd8)  return 3'd5;
    else                   return 3'd6;
  endfunction

endpackage

// File: rtl/cabac_bypass_step.sv
// One bypass-bin stage: shift the offset left, compare against the scaled range, subtract on hit.
module cabac_bypass_step
  import cabac_pkg::*;
(
  input  logic [VALUE_W-1:0] value,
  input  logic [VALUE_W-1:0] scaled,
  output logic               bin,
  output logic [EP_W-1:0]    value_next
);

  logic [EP_W-1:0] t;

  assign t          = {value, 1'b0};
  assign bin        = (t >= {1'b0, scaled});
  assign value_next = bin ? (t - {1'b0, scaled}) : t;

endmodule

// File: rtl/cabac_decoder.sv
// CABAC binary arithmetic decoding core: one regular bin or up to BIN_WIDTH bypass bins per cycle.
// Macro DECODER_MULTI_BYPASS_EN enables multi-bin bypass; otherwise one bypass bin per cycle.
module cabac_decoder
  import cabac_pkg::*;
#(
  parameter int unsigned BIN_WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 bypass,
  input  logic [1:0]           n_bin,
  input  logic [7:0]           pState_in,
  input  logic [VALUE_W-1:0]   m_value_binRE_in,
  input  logic [EP_W-1:0]      m_value_binEP0_in,
  input  logic [EP_W-1:0]      m_value_binEP1_in,
  input  logic [EP_W-1:0]      m_value_binEP2_in,
  output logic [BIN_WIDTH-1:0] bin,
  output logic [2:0]           numBits,
  output logic [VALUE_W-1:0]   m_value_binRE_out,
  output logic [EP_W-1:0]      m_value_binEP0_out,
  output logic [EP_W-1:0]      m_value_binEP1_out,
  output logic [EP_W-1:0]      m_value_binEP2_out
);

`ifdef DECODER_MULTI_BYPASS_EN
  localparam int unsigned NumSteps = BIN_WIDTH;
`else
  localparam int unsigned NumSteps = 1;
`endif

  logic [RANGE_W-1:0] range_q, range_d;
  logic [VALUE_W-1:0] value_q, value_d;

  // Regular path
  logic               mps, is_lps;
  logic [6:0]         q;
  logic [RANGE_W-1:0] lps, rmps, range_re;
  logic [VALUE_W-1:0] scaled_re;

  assign mps       = pState_in[7];
  assign q         = mps ? ~pState_in[6:0] : pState_in[6:0];
  assign lps       = lps_range(range_q[8:5], q[6:2]);
  assign rmps      = range_q - lps;
  assign scaled_re = {rmps, 7'd0};
  assign is_lps    = (value_q >= scaled_re);

  always_comb begin
    numBits           = 3'd0;
    m_value_binRE_out = '0;
    range_re          = '0;
    if (is_lps) begin
      numBits           = renorm_bits(lps);
      m_value_binRE_out = (value_q - scaled_re) << numBits;
      range_re          = lps << numBits;
    end else begin
      numBits           = {2'b00, rmps < 9'd256};
      m_value_binRE_out = value_q << numBits;
      range_re          = rmps << numBits;
    end
  end

  // Bypass chain; stages beyond NumSteps are tied off
  logic [VALUE_W-1:0]  scaled_ep;
  logic [2:0][EP_W-1:0] ep;
  logic [2:0]          ep_bin;
  logic [1:0]          nb_eff;

  assign scaled_ep = {range_q, 7'd0};

  for (genvar k = 0; k < 3; k++) begin : g_step
    if (k < NumSteps) begin : g_on
      logic [VALUE_W-1:0] v_src;
      if (k == 0) begin : g_first
        assign v_src = value_q;
      end else begin : g_chain
        assign v_src = ep[k-1][VALUE_W-1:0];
      end
      cabac_bypass_step u_step (
        .value      (v_src),
        .scaled     (scaled_ep),
        .bin        (ep_bin[k]),
        .value_next (ep[k])
      );
    end else begin : g_off
      assign ep[k]     = '0;
      assign ep_bin[k] = 1'b0;
    end
  end

  assign m_value_binEP0_out = ep[0];
  assign m_value_binEP1_out = ep[1];
  assign m_value_binEP2_out = ep[2];

`ifdef DECODER_MULTI_BYPASS_EN
  assign nb_eff = (n_bin > 2'(BIN_WIDTH - 1)) ? 2'(BIN_WIDTH - 1) : n_bin;
  logic unused_bits;
  assign unused_bits = ^{q[1:0], m_value_binEP0_in[16], m_value_binEP1_in[16],
                         m_value_binEP2_in[16]};
`else
  assign nb_eff = 2'd0;
  logic unused_bits;
  assign unused_bits = ^{q[1:0], n_bin, m_value_binEP0_in[16], m_value_binEP1_in,
                         m_value_binEP2_in};
`endif

  always_comb begin
    bin = '0;
    if (bypass) begin
      for (int k = 0; k < BIN_WIDTH; k++) begin
        bin[k] = ep_bin[k] & (2'(k) <= nb_eff);
      end
    end else begin
      bin[0] = is_lps ? ~mps : mps;
    end
  end

  always_comb begin
    range_d = range_q;
    value_d = value_q;
    if (!bypass) begin
      range_d = range_re;
      value_d = m_value_binRE_in;
    end else begin
`ifdef DECODER_MULTI_BYPASS_EN
      case (nb_eff)
        2'd0:    value_d = m_value_binEP0_in[VALUE_W-1:0];
        2'd1:    value_d = m_value_binEP1_in[VALUE_W-1:0];
        default: value_d = m_value_binEP2_in[VALUE_W-1:0];
      endcase
`else
      value_d = m_value_binEP0_in[VALUE_W-1:0];
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      range_q <= RANGE_RESET;
      value_q <= '0;
    end else begin
      range_q <= range_d;
      value_q <= value_d;
    end
  end

endmodule

// File: tb/tb_cabac_decoder.sv
// Directed bench for cabac_decoder with hand-computed expectations for both macro settings.
module tb_cabac_decoder;

  logic        clk;
  logic        reset;
  logic        bypass;
  logic [1:0]  n_bin;
  logic [7:0]  pState_in;
  logic [15:0] re_in;
  logic [16:0] ep0_in, ep1_in, ep2_in;
  logic [2:0]  bin;
  logic [2:0]  numBits;
  logic [15:0] re_out;
  logic [16:0] ep0_out, ep1_out, ep2_out;

  int n_cmp = 0;
  int n_err = 0;

  cabac_decoder #(.BIN_WIDTH(3)) dut (
    .clk                (clk),
    .reset              (reset),
    .bypass             (bypass),
    .n_bin              (n_bin),
    .pState_in          (pState_in),
    .m_value_binRE_in   (re_in),
    .m_value_binEP0_in  (ep0_in),
    .m_value_binEP1_in  (ep1_in),
    .m_value_binEP2_in  (ep2_in),
    .bin                (bin),
    .numBits            (numBits),
    .m_value_binRE_out  (re_out),
    .m_value_binEP0_out (ep0_out),
    .m_value_binEP1_out (ep1_out),
    .m_value_binEP2_out (ep2_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef DECODER_MULTI_BYPASS_EN
  localparam bit Multi = 1'b1;
`else
  localparam bit Multi = 1'b0;
`endif

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  task automatic load_value(input logic [15:0] v);
    bypass = 1'b1;
    n_bin  = 2'd0;
    ep0_in = {1'b0, v};
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; bypass = 1'b0; pState_in = 8'h00; re_in = 16'd0;
    #1;
    n_cmp++; if (dut.range_q !== 9'd510) begin
      $display("FAIL reset_range: got %0d expected 510", dut.range_q); n_err++; end
    n_cmp++; if (dut.value_q !== 16'd0) begin
      $display("FAIL reset_value: got %0d expected 0", dut.value_q); n_err++; end
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_cmp++; if (bin[0] !== 1'b0 || numBits !== 3'd0 || re_out !== 16'd0) begin
      $display("FAIL reset_regular: bin0=%0b nb=%0d re=%0d expected 0 0 0", bin[0], numBits, re_out);
      n_err++; end
    @(posedge clk); #1;
    n_cmp++; if (dut.range_q !== 9'd506) begin
      $display("FAIL reset_next_range: got %0d expected 506", dut.range_q); n_err++; end
  endtask

  task automatic test_lps_branch();
    do_reset();
    load_value(16'd65000);
    n_cmp++; if (dut.value_q !== 16'd65000) begin
      $display("FAIL lps_load: got %0d expected 65000", dut.value_q); n_err++; end
    bypass = 1'b0; pState_in = 8'h00; re_in = 16'd0;
    #1;
    n_cmp++; if (bin !== 3'b001 || numBits !== 3'd6 || re_out !== 16'd14848) begin
      $display("FAIL lps_out: bin=%b nb=%0d re=%0d expected 001 6 14848", bin, numBits, re_out);
      n_err++; end
    @(posedge clk); #1;
    n_cmp++; if (dut.range_q !== 9'd256 || dut.value_q !== 16'd0) begin
      $display("FAIL lps_state: range=%0d value=%0d expected 256 0", dut.range_q, dut.value_q);
      n_err++; end
  endtask

  task automatic test_mps_renorm();
    bypass = 1'b0; pState_in = 8'h7F; re_in = 16'd0;
    #1;
    n_cmp++; if (bin !== 3'b000 || numBits !== 3'd1 || re_out !== 16'd0) begin
      $display("FAIL mps_renorm_out: bin=%b nb=%0d re=%0d expected 000 1 0", bin, numBits, re_out);
      n_err++; end
    @(posedge clk); #1;
    n_cmp++; if (dut.range_q !== 9'd256) begin
      $display("FAIL mps_renorm_range: got %0d expected 256", dut.range_q); n_err++; end
  endtask

  task automatic test_mps_one();
    do_reset();
    load_value(16'd40000);
    // mps=1: lps=236, rmps=274, value above scaled -> LPS with bin 0
    bypass = 1'b0; pState_in = 8'h80; re_in = 16'd0;
    #1;
    n_cmp++; if (bin !== 3'b000 || numBits !== 3'd1 || re_out !== 16'd9856) begin
      $display("FAIL mps1_lps_out: bin=%b nb=%0d re=%0d expected 000 1 9856", bin, numBits, re_out);
      n_err++; end
    @(posedge clk); #1;
    n_cmp++; if (dut.range_q !== 9'd472) begin
      $display("FAIL mps1_lps_range: got %0d expected 472", dut.range_q); n_err++; end
    // range 472: lps=221, rmps=251 -> MPS bin 1 with one-bit renorm
    #1;
    n_cmp++; if (bin !== 3'b001 || numBits !== 3'd1 || re_out !== 16'd0) begin
      $display("FAIL mps1_mps_out: bin=%b nb=%0d re=%0d expected 001 1 0", bin, numBits, re_out);
      n_err++; end
    @(posedge clk); #1;
    n_cmp++; if (dut.range_q !== 9'd502) begin
      $display("FAIL mps1_mps_range: got %0d expected 502", dut.range_q); n_err++; end
  endtask

  task automatic test_bypass_multi();
    do_reset();
    load_value(16'd40000);
    bypass = 1'b1; n_bin = 2'd2;
    ep0_in = 17'd111; ep1_in = 17'd222; ep2_in = 17'd333;
    #1;
    n_cmp++; if (bin !== 3'b001 || ep0_out !== 17'd14720) begin
      $display("FAIL bypass_bin_ep0: bin=%b ep0=%0d expected 001 14720", bin, ep0_out); n_err++; end
    n_cmp++;
    if (ep1_out !== (Multi ? 17'd29440 : 17'd0) || ep2_out !== (Multi ? 17'd58880 : 17'd0)) begin
      $display("FAIL bypass_ep12: ep1=%0d ep2=%0d expected %0d %0d", ep1_out, ep2_out,
               Multi ? 29440 : 0, Multi ? 58880 : 0);
      n_err++; end
    @(posedge clk); #1;
    n_cmp++; if (dut.value_q !== (Multi ? 16'd333 : 16'd111) || dut.range_q !== 9'd510) begin
      $display("FAIL bypass_state: value=%0d range=%0d expected %0d 510", dut.value_q, dut.range_q,
               Multi ? 333 : 111);
      n_err++; end
  endtask

  task automatic test_bypass_clamp();
    // 60000 at range 510 yields three 1-bins: 54720, 44160, 23040
    load_value(16'd60000);
    bypass = 1'b1;
    ep0_in = 17'd1000; ep1_in = 17'd2000; ep2_in = 17'd3000;
    n_bin = 2'd0; #1;
    n_cmp++; if (bin !== 3'b001 || ep0_out !== 17'd54720) begin
      $display("FAIL clamp_n0: bin=%b ep0=%0d expected 001 54720", bin, ep0_out); n_err++; end
    n_bin = 2'd1; #1;
    n_cmp++; if (bin !== (Multi ? 3'b011 : 3'b001)) begin
      $display("FAIL clamp_n1: bin=%b expected %b", bin, Multi ? 3'b011 : 3'b001); n_err++; end
    n_bin = 2'd3; #1;
    n_cmp++; if (bin !== (Multi ? 3'b111 : 3'b001)) begin
      $display("FAIL clamp_n3: bin=%b expected %b", bin, Multi ? 3'b111 : 3'b001); n_err++; end
    n_cmp++; if (ep2_out !== (Multi ? 17'd23040 : 17'd0)) begin
      $display("FAIL clamp_ep2: got %0d expected %0d", ep2_out, Multi ? 23040 : 0); n_err++; end
    @(posedge clk); #1;
    n_cmp++; if (dut.value_q !== (Multi ? 16'd3000 : 16'd1000)) begin
      $display("FAIL clamp_load: got %0d expected %0d", dut.value_q, Multi ? 3000 : 1000);
      n_err++; end
  endtask

  task automatic test_async_reset();
    do_reset();
    load_value(16'd65000);
    bypass = 1'b0; pState_in = 8'h00; re_in = 16'd777;
    @(posedge clk); #1;
    n_cmp++; if (dut.range_q !== 9'd256 || dut.value_q !== 16'd777) begin
      $display("FAIL async_pre: range=%0d value=%0d expected 256 777", dut.range_q, dut.value_q);
      n_err++; end
    #2;
    reset = 1'b1;
    #1;
    n_cmp++; if (dut.range_q !== 9'd510 || dut.value_q !== 16'd0) begin
      $display("FAIL async_reset: range=%0d value=%0d expected 510 0", dut.range_q, dut.value_q);
      n_err++; end
    n_cmp++; if (bin !== 3'b000 || numBits !== 3'd0 || re_out !== 16'd0) begin
      $display("FAIL async_outputs: bin=%b nb=%0d re=%0d expected 000 0 0", bin, numBits, re_out);
      n_err++; end
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; bypass = 1'b0; n_bin = 2'd0; pState_in = 8'h00;
    re_in = '0; ep0_in = '0; ep1_in = '0; ep2_in = '0;
    test_reset();
    test_lps_branch();
    test_mps_renorm();
    test_mps_one();
    test_bypass_multi();
    test_bypass_clamp();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
